// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: FSM encodings and parameter defaults.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_POLL = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_INC_DEFAULT       = 2;
    localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'h0000;

    // The IDLE cycle that issues ADDR already counts as the first wait state.
    function automatic int unsigned wait_load_value(input int unsigned wait_states);
        return (wait_states > 1) ? wait_states - 1 : 0;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Phase strobes, jump request and instruction-memory bus seen by the fetch unit.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              FETCH;
    logic              DECODE;
    logic              EXECUTE;
    logic              COMMIT;
    logic              STOPPED;
    logic              JMP_REQ;
    logic              JMP_REL;
    logic [ADDR_W-1:0] JMP_OFFSET;
    logic              MEM_READY;
    logic              PC_ENX;
    logic [ADDR_W-1:0] ADDR;
    logic              RD;
    logic [ADDR_W-1:0] PC;
    logic              BUS_ERR;

    modport master (
        input  FETCH, DECODE, EXECUTE, COMMIT, STOPPED,
        input  JMP_REQ, JMP_REL, JMP_OFFSET, MEM_READY,
        output PC_ENX, ADDR, RD, PC, BUS_ERR
    );

    modport slave (
        output FETCH, DECODE, EXECUTE, COMMIT, STOPPED,
        output JMP_REQ, JMP_REL, JMP_OFFSET, MEM_READY,
        input  PC_ENX, ADDR, RD, PC, BUS_ERR
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_wait_timer.sv
// Loadable down-counter; expire flags the cycle whose decrement brings the count to zero.
module fetch_wait_timer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire
);
    logic [W-1:0] count_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign expire = (count_reg <= W'(1));
endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter owner and instruction-memory read sequencer; stalls FETCH until data is valid.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT),
    parameter int                PC_INC       = PC_INC_DEFAULT,
    parameter int                WAIT_STATES  = 1,
    parameter int                TIMEOUT      = 15
) (
    input  logic                       CLK,
    input  logic                       RESET,
    instruction_fetch_unit_if.master   bus
);
    localparam int            CW           = 8;
    localparam logic [CW-1:0] WAIT_LOAD    = CW'(wait_load_value(WAIT_STATES));
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT);

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] target_reg;
    logic              rd_reg;
    logic              bus_err_reg;
    logic              pending_reg;

    logic fetch_go;
    logic pc_enx;
    logic wait_load, wait_dec, wait_expire;
    logic to_load, to_dec, to_expire;

    assign fetch_go  = bus.FETCH && !bus.STOPPED;
    assign wait_load = (state_reg == FS_IDLE) && fetch_go;
    assign wait_dec  = (state_reg == FS_WAIT);
    assign to_load   = ((state_reg == FS_IDLE) && fetch_go && (WAIT_STATES <= 1)) ||
                       ((state_reg == FS_WAIT) && wait_expire);
    assign to_dec    = (state_reg == FS_POLL) && !bus.MEM_READY;

    fetch_wait_timer #(.W(CW)) u_wait_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .dec      (wait_dec),
        .expire   (wait_expire)
    );

    fetch_wait_timer #(.W(CW)) u_timeout_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (to_load),
        .load_val (TIMEOUT_LOAD),
        .dec      (to_dec),
        .expire   (to_expire)
    );

    // Combinational so the sequencer never leaves FETCH before the word is valid.
    always_comb begin
        pc_enx = 1'b1;
        unique case (state_reg)
            FS_IDLE: if (fetch_go) pc_enx = (WAIT_STATES == 0) ? bus.MEM_READY : 1'b0;
            FS_WAIT: pc_enx = 1'b0;
            FS_POLL: pc_enx = bus.MEM_READY || to_expire;
            FS_HOLD: pc_enx = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= FS_IDLE;
            addr_reg    <= RESET_VECTOR;
            rd_reg      <= 1'b0;
            bus_err_reg <= 1'b0;
        end else if (bus.STOPPED) begin
            state_reg <= FS_IDLE;
            rd_reg    <= 1'b0;
        end else begin
            unique case (state_reg)
                FS_IDLE: begin
                    if (bus.FETCH) begin
                        addr_reg <= pc_reg;
                        rd_reg   <= 1'b1;
                        if (WAIT_STATES == 0)
                            state_reg <= bus.MEM_READY ? FS_HOLD : FS_POLL;
                        else if (WAIT_STATES == 1)
                            state_reg <= FS_POLL;
                        else
                            state_reg <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (wait_expire) state_reg <= FS_POLL;
                end
                FS_POLL: begin
                    if (bus.MEM_READY) begin
                        state_reg <= FS_HOLD;
                    end else if (to_expire) begin
                        // Stale word is accepted; the fault is only flagged.
                        bus_err_reg <= 1'b1;
                        state_reg   <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (!bus.DECODE && !bus.FETCH) begin
                        state_reg <= FS_IDLE;
                        rd_reg    <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_reg      <= RESET_VECTOR;
            target_reg  <= '0;
            pending_reg <= 1'b0;
        end else if (!bus.STOPPED) begin
            if (pc_enx && bus.COMMIT) begin
                pc_reg      <= pending_reg ? target_reg : pc_reg + ADDR_W'(PC_INC);
                pending_reg <= 1'b0;
            end
            if (bus.EXECUTE && bus.JMP_REQ) begin
                target_reg  <= bus.JMP_REL ? pc_reg + bus.JMP_OFFSET : bus.JMP_OFFSET;
                pending_reg <= 1'b1;
            end
        end
    end

    assign bus.PC_ENX  = pc_enx;
    assign bus.ADDR    = addr_reg;
    assign bus.RD      = rd_reg;
    assign bus.PC      = pc_reg;
    assign bus.BUS_ERR = bus_err_reg;
endmodule
